// File: rtl/pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module  : pixel_fetch
// Purpose : Reads a packed 2bpp image from synchronous memory and streams the
//           colour indices in raster order over a valid/ready interface.
// Revision: 1.0 - initial release
// ============================================================================
module pixel_fetch #(
    parameter int IMG_W  = 160,
    parameter int IMG_H  = 144,
    parameter int ADDR_W = 13
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_frame_start,
    output logic              o_mem_rd,
    output logic [ADDR_W-1:0] o_mem_addr,
    input  logic [7:0]        i_mem_data,
    output logic [1:0]        o_color,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_last,
    output logic              o_frame_done
);

    localparam int NPIX   = IMG_W * IMG_H;
    localparam int NBYTES = NPIX / 4;
    localparam int PIX_W  = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int CNT_W  = ADDR_W + 1;

    localparam logic [PIX_W-1:0] c_LAST_PIX = PIX_W'(NPIX - 1);
    localparam logic [CNT_W-1:0] c_NBYTES   = CNT_W'(NBYTES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  rd_cnt_q;
    logic              mem_rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic              pend_q;
    logic [7:0]        fifo_q [2];
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        occ_q;
    logic [1:0]        pos_q;
    logic [PIX_W-1:0]  pix_cnt_q;
    logic              done_q;

    logic [7:0] w_head;
    logic [7:0] w_shift;
    logic       w_valid;
    logic       w_xfer;
    logic       w_pop;
    logic       w_can_rd;

    assign w_head   = fifo_q[rd_ptr_q];
    assign w_shift  = w_head << {pos_q, 1'b0};
    assign w_valid  = (occ_q != 2'd0);
    assign w_xfer   = w_valid & i_ready;
    assign w_pop    = w_xfer & (pos_q == 2'd3);
    // Reads still on the bus or in the memory pipeline count against FIFO space.
    assign w_can_rd = (({1'b0, occ_q} + {2'b00, mem_rd_q} + {2'b00, pend_q}) < 3'd2);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            rd_cnt_q  <= '0;
            mem_rd_q  <= 1'b0;
            addr_q    <= '0;
            pend_q    <= 1'b0;
            fifo_q[0] <= 8'h00;
            fifo_q[1] <= 8'h00;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            occ_q     <= 2'd0;
            pos_q     <= 2'd0;
            pix_cnt_q <= '0;
            done_q    <= 1'b0;
        end else if (i_frame_start) begin
            state_q   <= S_FETCH;
            mem_rd_q  <= 1'b1;
            addr_q    <= '0;
            rd_cnt_q  <= CNT_W'(1);
            pend_q    <= 1'b0;
            wr_ptr_q  <= 1'b0;
            rd_ptr_q  <= 1'b0;
            occ_q     <= 2'd0;
            pos_q     <= 2'd0;
            pix_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            pend_q   <= mem_rd_q;
            mem_rd_q <= 1'b0;

            case (state_q)
                S_FETCH: begin
                    if (rd_cnt_q == c_NBYTES) begin
                        state_q <= S_DRAIN;
                    end else if (w_can_rd) begin
                        mem_rd_q <= 1'b1;
                        addr_q   <= rd_cnt_q[ADDR_W-1:0];
                        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase

            if (pend_q) begin
                fifo_q[wr_ptr_q] <= i_mem_data;
                wr_ptr_q         <= ~wr_ptr_q;
            end
            occ_q <= occ_q + {1'b0, pend_q} - {1'b0, w_pop};

            if (w_xfer) begin
                pos_q <= pos_q + 2'd1;
                if (w_pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                if (pix_cnt_q == c_LAST_PIX) begin
                    pix_cnt_q <= '0;
                    done_q    <= 1'b1;
                    state_q   <= S_IDLE;
                end else begin
                    pix_cnt_q <= pix_cnt_q + PIX_W'(1);
                end
            end
        end
    end

    assign o_mem_rd     = mem_rd_q;
    assign o_mem_addr   = addr_q;
    assign o_color      = w_shift[7:6];
    assign o_valid      = w_valid;
    assign o_last       = w_valid & (pix_cnt_q == c_LAST_PIX);
    assign o_frame_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pixel_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_pixel_fetch
// Purpose : Directed self-checking bench for pixel_fetch (default and 4x2).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pixel_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        fs = 1'b0, ready = 1'b1;
    logic        mem_rd, valid, last, done;
    logic [12:0] mem_addr;
    logic [7:0]  mem_data = 8'h00;
    logic [1:0]  color;

    logic        s_fs = 1'b0, s_ready = 1'b1;
    logic        s_mem_rd, s_valid, s_last, s_done;
    logic [1:0]  s_mem_addr, s_color;
    logic [7:0]  s_mem_data = 8'h00;

    int mem_mode = 0;
    int checks = 0;
    int passes = 0;

    pixel_fetch #(.IMG_W(160), .IMG_H(144), .ADDR_W(13)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(fs),
        .o_mem_rd(mem_rd), .o_mem_addr(mem_addr), .i_mem_data(mem_data),
        .o_color(color), .o_valid(valid), .i_ready(ready),
        .o_last(last), .o_frame_done(done)
    );

    pixel_fetch #(.IMG_W(4), .IMG_H(2), .ADDR_W(2)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_frame_start(s_fs),
        .o_mem_rd(s_mem_rd), .o_mem_addr(s_mem_addr), .i_mem_data(s_mem_data),
        .o_color(s_color), .o_valid(s_valid), .i_ready(s_ready),
        .o_last(s_last), .o_frame_done(s_done)
    );

    function automatic logic [7:0] pat(input int a);
        return 8'(a * 37 + (a >> 8) + 5);
    endfunction

    function automatic logic [1:0] exp_pix(input int p);
        logic [7:0] b;
        b = pat(p / 4);
        return 2'(b >> (6 - 2 * (p % 4)));
    endfunction

    // Synchronous memories with one-cycle read latency.
    always @(posedge clk) if (mem_rd) mem_data <= (mem_mode == 0) ? 8'hE4 : pat(int'(mem_addr));
    always @(posedge clk) if (s_mem_rd) s_mem_data <= (s_mem_addr == 2'd0) ? 8'h1B : 8'hFF;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; fs = 1'b0; ready = 1'b1; s_fs = 1'b0; s_ready = 1'b1;
        repeat (3) step;
        checks++; if (mem_rd !== 1'b0) $display("FAIL rst_mem_rd: got %b want 0", mem_rd); else passes++;
        checks++; if (mem_addr !== 13'd0) $display("FAIL rst_mem_addr: got %0h want 0", mem_addr); else passes++;
        checks++; if (color !== 2'd0) $display("FAIL rst_color: got %0d want 0", color); else passes++;
        checks++; if (valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid); else passes++;
        checks++; if (last !== 1'b0) $display("FAIL rst_last: got %b want 0", last); else passes++;
        checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else passes++;
        checks++; if (s_valid !== 1'b0) $display("FAIL rst_s_valid: got %b want 0", s_valid); else passes++;
        rst_n = 1'b1;
        step;
        checks++; if (valid !== 1'b0 || mem_rd !== 1'b0) $display("FAIL idle_after_rst: valid=%b rd=%b want 0 0", valid, mem_rd); else passes++;
    endtask

    task automatic test_first_pixel;
        mem_mode = 0; ready = 1'b1;
        fs = 1'b1; step; fs = 1'b0;
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 13'd0) $display("FAIL start_rd0: rd=%b addr=%0d want 1 0", mem_rd, mem_addr); else passes++;
        checks++; if (valid !== 1'b0) $display("FAIL start_valid_n: got %b want 0", valid); else passes++;
        step;
        checks++; if (mem_rd !== 1'b1 || mem_addr !== 13'd1) $display("FAIL start_rd1: rd=%b addr=%0d want 1 1", mem_rd, mem_addr); else passes++;
        checks++; if (valid !== 1'b0) $display("FAIL start_valid_n1: got %b want 0", valid); else passes++;
        step;
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (valid !== 1'b1 || color !== 2'(3 - (i % 4)))
                $display("FAIL e4_pix%0d: valid=%b color=%0d want 1 %0d", i, valid, color, 3 - (i % 4));
            else passes++;
            step;
        end
    endtask

    task automatic test_small;
        logic [1:0] s_exp [8];
        int n, nrd, k_last, k_done, ndone;
        s_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        n = 0; nrd = 0; k_last = -1; k_done = -1; ndone = 0;
        s_fs = 1'b1; step; s_fs = 1'b0;
        for (int k = 0; k < 25; k++) begin
            if (s_mem_rd) begin
                checks++; if (s_mem_addr !== 2'(nrd)) $display("FAIL small_addr%0d: got %0d want %0d", nrd, s_mem_addr, nrd); else passes++;
                nrd++;
            end
            if (s_done) begin ndone++; if (k_done < 0) k_done = k; end
            if (s_valid) begin
                if (n < 8) begin
                    checks++; if (s_color !== s_exp[n]) $display("FAIL small_pix%0d: got %0d want %0d", n, s_color, s_exp[n]); else passes++;
                    checks++; if (s_last !== (n == 7)) $display("FAIL small_last%0d: got %b want %b", n, s_last, (n == 7)); else passes++;
                end
                if (n == 7) k_last = k;
                n++;
            end
            step;
        end
        checks++; if (n != 8) $display("FAIL small_count: got %0d want 8", n); else passes++;
        checks++; if (nrd != 2) $display("FAIL small_reads: got %0d want 2", nrd); else passes++;
        checks++; if (ndone != 1) $display("FAIL small_done_cnt: got %0d want 1", ndone); else passes++;
        checks++; if (k_last < 0 || k_done != k_last + 1) $display("FAIL small_done_time: got %0d want %0d", k_done, k_last + 1); else passes++;
    endtask

    task automatic test_coincident;
        logic [1:0] s_exp [8];
        int n, early, ndone;
        bit found;
        s_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
        s_fs = 1'b1; step; s_fs = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (s_valid && s_last) found = 1'b1; else step;
        end
        checks++; if (!found) $display("FAIL coinc_reach_last: got 0 want 1"); else passes++;
        s_fs = 1'b1; step; s_fs = 1'b0;
        n = 0; early = 0; ndone = 0;
        for (int k = 0; k < 25; k++) begin
            if (s_done) begin if (n < 8) early++; else ndone++; end
            if (s_valid) begin
                if (n < 8) begin
                    checks++; if (s_color !== s_exp[n]) $display("FAIL coinc_pix%0d: got %0d want %0d", n, s_color, s_exp[n]); else passes++;
                end
                n++;
            end
            step;
        end
        checks++; if (early != 0) $display("FAIL coinc_no_done: got %0d want 0", early); else passes++;
        checks++; if (n != 8) $display("FAIL coinc_count: got %0d want 8", n); else passes++;
        checks++; if (ndone != 1) $display("FAIL coinc_new_done: got %0d want 1", ndone); else passes++;
    endtask

    task automatic test_restart;
        int n, m, sawdone;
        mem_mode = 1; ready = 1'b1;
        fs = 1'b1; step; fs = 1'b0;
        n = 0;
        for (int k = 0; k < 200 && n < 100; k++) begin
            if (valid) begin
                checks++; if (color !== exp_pix(n)) $display("FAIL restart_pre%0d: got %0d want %0d", n, color, exp_pix(n)); else passes++;
                n++;
            end
            if (n < 100) step;
        end
        checks++; if (n != 100) $display("FAIL restart_reach100: got %0d want 100", n); else passes++;
        step;
        fs = 1'b1; ready = 1'b0; step; fs = 1'b0; ready = 1'b1;
        m = 0; sawdone = 0;
        for (int k = 0; k < 30; k++) begin
            if (done) sawdone++;
            if (valid && m < 8) begin
                checks++; if (color !== exp_pix(m)) $display("FAIL restart_post%0d: got %0d want %0d", m, color, exp_pix(m)); else passes++;
                m++;
            end
            step;
        end
        checks++; if (m != 8) $display("FAIL restart_count: got %0d want 8", m); else passes++;
        checks++; if (sawdone != 0) $display("FAIL restart_no_done: got %0d want 0", sawdone); else passes++;
    endtask

    task automatic test_async_reset;
        checks++; if (valid !== 1'b1) $display("FAIL arst_pre_valid: got %b want 1", valid); else passes++;
        #3 rst_n = 1'b0;
        #1;
        checks++; if (valid !== 1'b0 || mem_rd !== 1'b0) $display("FAIL arst_immediate: valid=%b rd=%b want 0 0", valid, mem_rd); else passes++;
        checks++; if (last !== 1'b0 || done !== 1'b0 || color !== 2'd0) $display("FAIL arst_outputs: last=%b done=%b color=%0d want 0 0 0", last, done, color); else passes++;
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step;
            checks++; if (valid !== 1'b0 || mem_rd !== 1'b0) $display("FAIL arst_idle%0d: valid=%b rd=%b want 0 0", k, valid, mem_rd); else passes++;
        end
        fs = 1'b1; step; fs = 1'b0;
        checks++; if (mem_rd !== 1'b1) $display("FAIL arst_restart_rd: got %b want 1", mem_rd); else passes++;
        step; step;
        checks++; if (valid !== 1'b1 || color !== exp_pix(0)) $display("FAIL arst_restart_pix: valid=%b color=%0d want 1 %0d", valid, color, exp_pix(0)); else passes++;
    endtask

    task automatic test_back_to_back_stall;
        int n, nrd, ndone;
        bit prev_stall;
        logic [1:0] prev_color;
        mem_mode = 1; ready = 1'b1;
        fs = 1'b1; step; fs = 1'b0;
        n = 0; nrd = 0; ndone = 0; prev_stall = 1'b0; prev_color = 2'd0;
        for (int k = 0; k < 70000 && ndone == 0; k++) begin
            if (mem_rd) begin
                checks++; if (mem_addr !== 13'(nrd)) $display("FAIL bp_addr%0d: got %0d want %0d", nrd, mem_addr, nrd); else passes++;
                nrd++;
            end
            checks++; if (nrd - n / 4 > 2) $display("FAIL bp_occupancy: got %0d want <=2", nrd - n / 4); else passes++;
            if (prev_stall) begin
                checks++; if (valid !== 1'b1 || color !== prev_color) $display("FAIL bp_stable: valid=%b color=%0d want 1 %0d", valid, color, prev_color); else passes++;
            end
            if (done) begin
                ndone++;
                checks++; if (n != 23040) $display("FAIL bp_done_early: got %0d want 23040", n); else passes++;
            end
            ready = 1'($urandom_range(0, 1));
            prev_stall = valid && !ready;
            prev_color = color;
            if (valid && ready) begin
                checks++; if (color !== exp_pix(n)) $display("FAIL bp_pix%0d: got %0d want %0d", n, color, exp_pix(n)); else passes++;
                checks++; if (last !== (n == 23039)) $display("FAIL bp_last%0d: got %b want %b", n, last, (n == 23039)); else passes++;
                n++;
            end
            step;
        end
        checks++; if (ndone != 1) $display("FAIL bp_done_seen: got %0d want 1", ndone); else passes++;
        checks++; if (n != 23040) $display("FAIL bp_count: got %0d want 23040", n); else passes++;
        checks++; if (nrd != 5760) $display("FAIL bp_reads: got %0d want 5760", nrd); else passes++;
        checks++; if (done !== 1'b0 || valid !== 1'b0 || mem_rd !== 1'b0) $display("FAIL bp_after: done=%b valid=%b rd=%b want 0 0 0", done, valid, mem_rd); else passes++;
        ready = 1'b1;
    endtask

    initial begin
        test_reset;
        test_first_pixel;
        test_small;
        test_coincident;
        test_restart;
        test_async_reset;
        test_back_to_back_stall;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pixel_fetch.md
# pixel_fetch

Streams 2-bit colour indices, in raster order, out of a packed 2-bits-per-pixel image memory to the palette stage. The palette stage converts each index to RGB565 for the LCD.
- Issues byte reads to a synchronous memory (one-cycle read latency).
- Buffers returned bytes in a small prefetch FIFO.
- Unpacks each byte into four indices and presents them on a valid/ready stream.
- A frame-start strobe from the LCD timing generator restarts the image at pixel 0.

## Interface
Parameters:
- IMG_W, 160: image width in pixels.
- IMG_H, 144: image height in pixels. IMG_W*IMG_H must be divisible by 4.
- ADDR_W, 13: memory address width. 2**ADDR_W must be at least IMG_W*IMG_H/4.

Ports:
- i_clk  input  1  sole clock; all logic on rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_frame_start  input  1  one-cycle strobe; flush and restart at pixel 0.
- o_mem_rd  output  1  read strobe to image memory.
- o_mem_addr  output  ADDR_W  byte address, valid while o_mem_rd is high.
- i_mem_data  input  8  read data, valid in the cycle after o_mem_rd.
- o_color  output  2  colour index to the palette stage.
- o_valid  output  1  o_color holds a pixel.
- i_ready  input  1  downstream accepts the pixel this cycle.
- o_last  output  1  high with the final pixel of the frame.
- o_frame_done  output  1  one-cycle pulse after the final pixel is accepted.

## Operation
- Total bytes per frame: NBYTES = IMG_W*IMG_H/4.
- Byte packing: pixel 4k+0 is bits [7:6], 4k+1 is [5:4], 4k+2 is [3:2], 4k+3 is [1:0]. Byte k sits at address k.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE: no reads. o_valid is low.
  - i_frame_start in any state clears the FIFO, the in-flight read, the unpack position and the address counter, then enters FETCH.
  - FETCH: assert o_mem_rd with o_mem_addr = read counter whenever the condition below holds; increment the read counter on each read.
    - Read condition: FIFO occupancy + in-flight reads < 2.
    - When the read counter reaches NBYTES, enter DRAIN.
  - DRAIN: no more reads. The frame ends when pixel NBYTES*4-1 is accepted; then pulse o_frame_done and enter IDLE.
- Prefetch FIFO:
  - 2 entries of 8 bits.
  - Written from i_mem_data in the cycle after o_mem_rd.
  - Never overflows, because of the read condition.
- Unpacker:
  - Holds the head byte and a 2-bit position counter.
  - o_valid is high when the head entry exists.
  - o_color is the field selected by the position counter.
  - On each transfer (o_valid & i_ready) the position counter increments. When it wraps 3→0, the head entry is popped.
  - If the FIFO is popped and written in the same cycle, the occupancy is unchanged.
- o_last = o_valid & (pixel counter == NBYTES*4-1).
- o_color and o_valid hold steady while i_ready is low (no combinational path from i_ready to o_valid).
- i_frame_start in the same cycle as a transfer: the transfer is discarded from the count and the restart wins. o_frame_done is not pulsed.
- i_frame_start during DRAIN or FETCH aborts the current frame silently.

## Timing
- Reset values: o_mem_rd=0, o_mem_addr=0, o_color=0, o_valid=0, o_last=0, o_frame_done=0. FSM is in IDLE, FIFO is empty, all counters are 0.
- Start-up latency, with i_frame_start sampled at edge N:
  - o_mem_rd=1, addr 0 during cycle N..N+1.
  - Data written at edge N+2.
  - o_valid=1 from edge N+2.
  - First pixel latency: 2 cycles.
- Reads:
  - A second read (addr 1) is issued in cycle N+1..N+2, in parallel with the first.
  - Steady state: at most one read per 4 accepted pixels, plus the prefetch.
- Throughput: with i_ready held high, one pixel per cycle continuously. There are no bubbles across byte boundaries.
- o_frame_done goes high in the cycle after the last transfer edge, for exactly one cycle.
- Asynchronous reset mid-frame forces all outputs to reset values immediately. The block stays in IDLE until the next i_frame_start.

## Test plan
- Reset then frame start, memory model returning 0xE4 at every address, i_ready=1:
  - o_valid rises 2 cycles after the strobe.
  - o_color repeats 3,2,1,0 every cycle.
- Small image, IMG_W=4, IMG_H=2, bytes {0x1B,0xFF}, i_ready=1:
  - Output is 0,1,2,3,3,3,3,3.
  - o_last is high on the 8th pixel; o_frame_done pulses one cycle later.
  - Exactly 2 reads, at addresses 0 and 1.
- Backpressure: toggle i_ready pseudo-randomly at 50% for a full default frame.
  - All 23040 pixels arrive in order, none dropped or duplicated.
  - o_color is stable while stalled.
  - FIFO occupancy never exceeds 2.
- Restart: assert i_frame_start after 100 accepted pixels.
  - The next accepted pixel comes from address 0, bits [7:6].
  - No o_frame_done for the aborted frame.
- Async reset: drop i_rst_n for 1 cycle mid-frame.
  - o_valid and o_mem_rd go 0 immediately and stay 0 until the next i_frame_start.
- Strobe coincident with the last transfer:
  - No o_frame_done.
  - The new frame starts at pixel 0.
